imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction-side responder for the datapath fetch port: returns `m_data` for the word address `m_addr` driven by the processor.
- Memory contents arrive first over a byte-stream load interface with a valid/ready handshake.
- Holds the processor stalled through `pc_en` until loading completes, then serves fetches.
- Sits between the host/boot byte source and the datapath's `m_addr`/`m_data`/`pc_en` pins.

Parameters:
- ADDR_W, 5, word-address width; depth DEPTH = 2**ADDR_W words.
- NOP_WORD, 32'h00000013, value returned for unloaded words and during load (RV32I `addi x0,x0,0`).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- m_addr  input  ADDR_W  word address from the datapath fetch stage.
- m_data  output  32  instruction word for `m_addr`; combinational read.
- pc_en  output  1  high only in RUN; gates the datapath PC register.
- ld_valid  input  1  `ld_byte` is valid this cycle.
- ld_byte  input  8  load byte; little-endian within each word.
- ld_last  input  1  qualifies the final byte of the image when `ld_valid` is high.
- ld_ready  output  1  loader accepts a byte this cycle.
- load_done  output  1  high in RUN.
- word_count  output  ADDR_W+1  number of words written since reset, 0..DEPTH.

Behaviour:
- Reset, one cycle with `rst` high:
  - state = LOAD; byte_idx = 0; word_ptr = 0; word_count = 0.
  - All per-word valid bits cleared; shift buffer = 0.
  - Outputs: pc_en = 0, load_done = 0, ld_ready = 1, m_data = NOP_WORD.
  - Memory array is not cleared; the valid bits mask it.
- A byte transfer occurs when `ld_valid && ld_ready` at a rising edge. Nothing is accepted while `ld_ready` = 0.
- State LOAD:
  - `ld_ready` = 1.
  - Each accepted byte is placed at bits [8*byte_idx +: 8] of the shift buffer, then byte_idx increments mod 4.
  - When the accepted byte has byte_idx = 3, or `ld_last` = 1:
    - The assembled word is written to mem[word_ptr] with unaccepted upper bytes zero-filled.
    - valid[word_ptr] is set; word_ptr and word_count increment; the buffer clears.
  - Transition to RUN on the edge that writes a word with `ld_last` = 1, or that writes word DEPTH-1 (memory full).
  - A write is visible on `m_data` from the cycle after the edge.
- State RUN:
  - `ld_ready` = 0, `pc_en` = 1, `load_done` = 1.
  - RUN is absorbing; only `rst` leaves it.
- `m_data`:
  - In LOAD: always NOP_WORD.
  - In RUN: mem[m_addr] if valid[m_addr], else NOP_WORD.
  - Zero latency, purely combinational from `m_addr` and state, matching a single-cycle fetch.
- `pc_en` rises on the first cycle of RUN. The datapath PC, already reset to 0, fetches word 0 first.
- Boundary cases:
  - `ld_last` on byte_idx 0 writes a word containing one byte.
  - `ld_last` on a byte that also completes a word writes once, not twice.
  - 4*DEPTH bytes without `ld_last` → RUN after the final byte. Further bytes are refused via `ld_ready` = 0.
  - `rst` mid-load discards the partial buffer and all valid bits. A fresh load must restart from byte 0.
  - `rst` and `ld_valid` in the same cycle: reset wins, the byte is not accepted.
  - `word_count` saturates at DEPTH and never wraps.
  - `m_addr` values are always in range, since ADDR_W bits index exactly DEPTH words.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` [31:0], reset to 0.
  - On every word write, checksum <= checksum + written word (mod 2^32, including zero padding).
  - It is stable once in RUN, so the host can verify the image.
- When undefined: no port, no adder, identical behaviour otherwise.

Test Plan:
- Reset then idle: pc_en = 0, ld_ready = 1, m_data = 32'h00000013 for m_addr = 0..31; word_count = 0.
- Load bytes 93,00,50,00, 13,05,A0,00 with `ld_last` on the last byte → RUN one cycle after the final byte:
  - m_addr = 0 → 32'h00500093; m_addr = 1 → 32'h00A00513.
  - m_addr = 2 → 32'h00000013; word_count = 2; pc_en = 1.
  - With checksum enabled: checksum = 32'h00F005A6.
- Partial word: bytes 37,12 with `ld_last` on 12 → mem[0] = 32'h00001237, word_count = 1, RUN.
- Full memory: 128 bytes with pattern byte = index, no `ld_last` → RUN after byte 127:
  - m_addr = 31 → 32'h7F7E7D7C.
  - A byte 129 offered with `ld_valid` high is not accepted (`ld_ready` = 0); word_count = 32.
- Reset mid-load: 6 bytes, assert rst, then reload A, B, C, D with `ld_last`:
  - Only word 0 = 32'hDDCCBBAA is valid.
  - m_addr = 1 → 32'h00000013.
- Backpressure/gaps: `ld_valid` toggles every other cycle for 8 bytes → same result as the back-to-back load; no byte is duplicated or dropped.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory that is filled from a byte stream, then serves single-cycle fetches.
// Optional running image checksum output enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W   = 5,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_data,
    output logic              pc_en,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,output logic [31:0]       checksum
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_ptr;
    logic [CNT_W-1:0]  r_word_count;
    logic [DEPTH-1:0]  r_valid;
    logic [31:0]       r_buf;
    logic [31:0]       r_mem [DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       r_checksum;
`endif

    logic              w_accept;
    logic              w_write;
    logic              w_full;
    logic [31:0]       w_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte acceptance, word completion and the LOAD -> RUN decision.
    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        pc_en       = 1'b0;
        load_done   = 1'b0;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        w_full      = (r_word_ptr == ADDR_W'(DEPTH - 1));
        w_word      = r_buf | (32'(ld_byte) << {r_byte_idx, 3'b000});
        case (r_state)
            S_LOAD: begin
                ld_ready = 1'b1;
                w_accept = ld_valid && !rst;
                w_write  = w_accept && ((r_byte_idx == 2'd3) || ld_last);
                if (w_write && (ld_last || w_full)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                pc_en     = 1'b1;
                load_done = 1'b1;
            end
        endcase
    end

    // Buffer, pointers and valid bits; the array itself is masked rather than cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx   <= 2'd0;
            r_word_ptr   <= '0;
            r_word_count <= '0;
            r_valid      <= '0;
            r_buf        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_write) begin
                r_buf               <= '0;
                r_valid[r_word_ptr] <= 1'b1;
                r_word_ptr          <= r_word_ptr + ADDR_W'(1);
                if (r_word_count < CNT_W'(DEPTH)) begin
                    r_word_count <= r_word_count + CNT_W'(1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_checksum <= r_checksum + w_word;
`endif
            end else begin
                r_buf <= w_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_word_ptr] <= w_word;
        end
    end

    assign m_data     = ((r_state == S_RUN) && r_valid[m_addr]) ? r_mem[m_addr] : NOP_WORD;
    assign word_count = r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected words queued at load time, drained by fetch reads in RUN.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_data;
    logic              pc_en;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_byte = 8'h00;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .pc_en      (pc_en),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .load_done  (load_done),
        .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
       ,.checksum   (checksum)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offers one byte, optionally after an idle cycle; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic gap);
        int budget = 0;
        if (gap) @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!ld_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte_timeout: ld_ready stuck at %0b, required 1", ld_ready);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %0b want 0", pc_en); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %0b want 1", ld_ready); end
        n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %0b want 0", load_done); end
        n_cmp++; if (word_count !== '0) begin n_fail++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        for (int a = 0; a < DEPTH; a++) begin
            m_addr = ADDR_W'(a);
            #1;
            n_cmp++;
            if (m_data !== NOP) begin n_fail++; $display("FAIL reset_m_data[%0d]: got %h want %h", a, m_data, NOP); end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_cmp++; if (checksum !== 32'h0) begin n_fail++; $display("FAIL reset_checksum: got %h want 0", checksum); end
`endif
    endtask

    task automatic test_two_words(input logic gap, input string tag);
        logic [7:0] b [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        int a;
        do_reset();
        exp_q.push_back(32'h0050_0093);
        exp_q.push_back(32'h00A0_0513);
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], (i == 7), gap);
            if (i == 3) begin
                m_addr = '0;
                #1;
                n_cmp++; if (m_data !== NOP) begin n_fail++; $display("FAIL %s_load_m_data: got %h want %h", tag, m_data, NOP); end
                n_cmp++; if (word_count !== 6'd1) begin n_fail++; $display("FAIL %s_mid_count: got %0d want 1", tag, word_count); end
                n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL %s_mid_pc_en: got %0b want 0", tag, pc_en); end
            end
        end
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL %s_pc_en: got %0b want 1", tag, pc_en); end
        n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL %s_load_done: got %0b want 1", tag, load_done); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ld_ready: got %0b want 0", tag, ld_ready); end
        n_cmp++; if (word_count !== 6'd2) begin n_fail++; $display("FAIL %s_word_count: got %0d want 2", tag, word_count); end
        a = 0;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            m_addr = ADDR_W'(a);
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (m_data !== e) begin n_fail++; $display("FAIL %s_word[%0d]: got %h want %h", tag, a, m_data, e); end
            a++;
        end
        m_addr = ADDR_W'(2);
        #1;
        n_cmp++; if (m_data !== NOP) begin n_fail++; $display("FAIL %s_word[2]: got %h want %h", tag, m_data, NOP); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_cmp++; if (checksum !== 32'h00F0_05A6) begin n_fail++; $display("FAIL %s_checksum: got %h want 00f005a6", tag, checksum); end
`endif
    endtask

    task automatic test_partial();
        do_reset();
        exp_q.push_back(32'h0000_1237);
        send_byte(8'h37, 1'b0, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL partial_pc_en: got %0b want 1", pc_en); end
        n_cmp++; if (word_count !== 6'd1) begin n_fail++; $display("FAIL partial_word_count: got %0d want 1", word_count); end
        m_addr = '0;
        #1;
        begin
            logic [31:0] e = exp_q.pop_front();
            n_cmp++; if (m_data !== e) begin n_fail++; $display("FAIL partial_word[0]: got %h want %h", m_data, e); end
        end
        m_addr = ADDR_W'(1);
        #1;
        n_cmp++; if (m_data !== NOP) begin n_fail++; $display("FAIL partial_word[1]: got %h want %h", m_data, NOP); end
    endtask

    task automatic test_full();
        int a;
        do_reset();
        for (int w = 0; w < DEPTH; w++)
            exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        for (int i = 0; i < 4*DEPTH; i++) begin
            send_byte(8'(i), 1'b0, 1'b0);
            if (i == 4*DEPTH - 2) begin
                n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL full_early_run: pc_en %0b want 0", pc_en); end
            end
        end
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL full_pc_en: got %0b want 1", pc_en); end
        n_cmp++; if (word_count !== 6'd32) begin n_fail++; $display("FAIL full_word_count: got %0d want 32", word_count); end
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = 8'h80;
        ld_last  = 1'b1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_extra_ready: got %0b want 0", ld_ready); end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_cmp++; if (word_count !== 6'd32) begin n_fail++; $display("FAIL full_sat_count: got %0d want 32", word_count); end
        a = 0;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            m_addr = ADDR_W'(a);
            #1;
            e = exp_q.pop_front();
            n_cmp++; if (m_data !== e) begin n_fail++; $display("FAIL full_word[%0d]: got %h want %h", a, m_data, e); end
            a++;
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (word_count !== 6'd1) begin n_fail++; $display("FAIL midload_pre_count: got %0d want 1", word_count); end
        // Reset with a byte offered in the same cycle: reset must win.
        @(negedge clk);
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        ld_last  = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_cmp++; if (word_count !== '0) begin n_fail++; $display("FAIL midload_rst_count: got %0d want 0", word_count); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL midload_rst_ready: got %0b want 1", ld_ready); end
        exp_q.push_back(32'hDDCC_BBAA);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'hDD, 1'b1, 1'b0);
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL midload_pc_en: got %0b want 1", pc_en); end
        n_cmp++; if (word_count !== 6'd1) begin n_fail++; $display("FAIL midload_word_count: got %0d want 1", word_count); end
        m_addr = '0;
        #1;
        begin
            logic [31:0] e = exp_q.pop_front();
            n_cmp++; if (m_data !== e) begin n_fail++; $display("FAIL midload_word[0]: got %h want %h", m_data, e); end
        end
        m_addr = ADDR_W'(1);
        #1;
        n_cmp++; if (m_data !== NOP) begin n_fail++; $display("FAIL midload_word[1]: got %h want %h", m_data, NOP); end
    endtask

    initial begin
        test_reset();
        test_two_words(1'b0, "basic");
        test_partial();
        test_full();
        test_reset_midload();
        test_two_words(1'b1, "gaps");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
